// File: rtl/jkff_down_counter_pkg.sv
// Shared definitions for the JK flip-flop counter family: control state
// encoding and the default counter width.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEFAULT = 4;

endpackage

// File: rtl/jkff_down_counter_cell.sv
// One JK flip-flop bit-cell with a synchronous parallel-load override.
// Reset is synchronous active-low; ld beats j/k.
module jkff_load_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else begin
      unique case ({j, k})
        2'b11:   q <= ~q;
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jkff_down_counter.sv
// Loadable synchronous down counter built from toggle-mode JK cells, with
// free-running wrap mode (borrow pulse) and one-shot mode (stop at zero, done).
module jkff_down_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             one_shot,
  output logic [WIDTH-1:0] q,
  output logic             borrow,
  output logic             done,
  output logic             busy
);

  if (WIDTH < 2) begin : g_bad_width
    $error("jkff_down_counter: WIDTH must be at least 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic             q_zero;
  logic             q_one;
  logic             cnt_en;
  logic [WIDTH-1:0] t;

  assign q_zero = (q == '0);
  assign q_one  = (q == WIDTH'(1));

  // A one-shot counter sitting at zero must not toggle into all-ones.
  assign cnt_en = (state == ST_RUN) & en & ~(one_shot & q_zero);

  // Bit i toggles when all lower bits are 0; each t[i] is built straight
  // from q rather than from t[i-1] to keep the chain free of self-reference.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    if (gi == 0) begin : g_lsb
      assign t[gi] = cnt_en;
    end else begin : g_upper
      assign t[gi] = cnt_en & ~|q[gi-1:0];
    end

    jkff_load_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (t[gi]),
      .k     (t[gi]),
      .ld    (load),
      .d     (load_val[gi]),
      .q     (q[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = (one_shot && load_val == '0) ? ST_DONE : ST_RUN;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_RUN: begin
          if (en && one_shot && (q_one || q_zero)) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Borrow flags only an edge that actually wraps: reset or load override it.
  always_comb begin
    borrow = rst_n & ~load & (state == ST_RUN) & en & ~one_shot & q_zero;
    done   = (state == ST_DONE);
    busy   = (state == ST_RUN);
  end

endmodule

// File: tb/tb_jkff_down_counter.sv
// Scoreboard bench for jkff_down_counter (WIDTH=4): driver pushes expected
// responses from an arithmetic model, a monitor pops and compares each cycle.
module tb_jkff_down_counter;

  localparam int unsigned W    = 4;
  localparam int unsigned MODV = 16;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         one_shot;
  logic [W-1:0] q;
  logic         borrow;
  logic         done;
  logic         busy;

  jkff_down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .one_shot (one_shot),
    .q        (q),
    .borrow   (borrow),
    .done     (done),
    .busy     (busy)
  );

  typedef struct {
    logic       b;
    logic [3:0] q;
    logic       d;
    logic       bs;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 0;

  // Reference model: plain integer count plus a mode word.
  int m_cnt  = 0;
  int m_mode = 0;  // 0 idle, 1 running, 2 finished

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic l, input int lv,
                     input logic e, input logic o);
    exp_t x;
    @(negedge clk);
    rst_n    = r;
    load     = l;
    load_val = lv[3:0];
    en       = e;
    one_shot = o;
    x.b = r && !l && m_mode == 1 && e && !o && m_cnt == 0;
    if (!r) begin
      m_cnt  = 0;
      m_mode = 0;
    end else if (l) begin
      m_cnt  = lv % MODV;
      m_mode = (o && m_cnt == 0) ? 2 : 1;
    end else if (m_mode == 1 && e) begin
      if (m_cnt == 0) begin
        if (o) m_mode = 2;
        else   m_cnt = MODV - 1;
      end else begin
        m_cnt = m_cnt - 1;
        if (o && m_cnt == 0) m_mode = 2;
      end
    end
    x.q  = 4'(m_cnt);
    x.d  = (m_mode == 2);
    x.bs = (m_mode == 1);
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    while (!(stim_done && sb.size() == 0)) begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("borrow", int'(borrow), int'(e.b));
        @(posedge clk);
        #1;
        chk("q", int'(q), int'(e.q));
        chk("done", int'(done), int'(e.d));
        chk("busy", int'(busy), int'(e.bs));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bit os;
    rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; one_shot = 1'b0;
    // reset wins over a simultaneous load
    repeat (2) cyc(0, 1, 9, 0, 0);
    // one-shot: load 5, count to 0, then hold
    cyc(1, 1, 5, 0, 1);
    repeat (15) cyc(1, 0, 0, 1, 1);
    // wrap: load 2, run past two borrows
    cyc(1, 1, 2, 0, 0);
    repeat (22) cyc(1, 0, 0, 1, 0);
    // enable gap then load together with en
    cyc(1, 1, 8, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 3, 1, 0);
    cyc(1, 0, 0, 1, 0);
    // one-shot load of zero finishes at once
    cyc(1, 1, 0, 1, 1);
    repeat (3) cyc(1, 0, 0, 1, 1);
    // reset mid-count at q=4, then idle ignores en
    cyc(1, 1, 6, 0, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(0, 1, 7, 1, 1);
    repeat (4) cyc(1, 0, 0, 1, 0);
    // all cells toggle together: 0 -> 15
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    // one_shot switched on while sitting at 0
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    // randomized traffic
    os = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) os = ~os;
      cyc($urandom_range(63) != 0, $urandom_range(7) == 0,
          int'($urandom_range(15)), $urandom_range(3) != 0, os);
    end
    stim_done = 1;
  end

endmodule

// File: doc/jkff_down_counter.md
# jkff_down_counter

Synchronous down counter with parallel load. Its bit-cells are JK flip-flops wired in toggle mode, so a bit toggles when every lower bit is 0. It is the counting-down companion to the team's JK up-counter, for use as a reload timer or event down-counter. It supports two end-of-count modes:

- **Wrap**: free-running, wraps to all-ones and flags a borrow.
- **One-shot**: stops at zero and raises `done`.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits, minimum 2.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `load`, input, 1: load `load_val` into `q` and (re)start counting.
- `load_val`, input, `WIDTH`: parallel load value.
- `en`, input, 1: count enable; decrements once per cycle while running.
- `one_shot`, input, 1: 1 selects one-shot mode, 0 selects wrap mode. Sampled every cycle.
- `q`, output, `WIDTH`: current count, registered.
- `borrow`, output, 1: combinational; high in the cycle whose edge wraps `q` from 0 to all-ones.
- `done`, output, 1: registered; high while in `DONE`.
- `busy`, output, 1: registered; high while in `RUN`.

## Operation
- **States**:
  - `IDLE`: after reset; `q` holds its value and `en` is ignored.
  - `RUN`: counting.
  - `DONE`: one-shot finished; `q` holds at 0.
- **Priority per edge**: `rst_n`=0 first, then `load`, then counting.
- **Reset**:
  - `q` = 0, state `IDLE`.
  - `done` = 0, `busy` = 0, `borrow` = 0.
- **load**, accepted in any state:
  - `q` ← `load_val`.
  - Next state is `RUN`.
  - Exception: if `one_shot`=1 and `load_val`=0, next state is `DONE` directly and no `borrow` is generated.
- **In `RUN` with `en`=1 and `q`≠0**: `q` ← `q`−1.
- **In `RUN` with `en`=1, `q`=1 and `one_shot`=1**: `q` ← 0 and next state is `DONE`.
- **In `RUN` with `en`=1, `q`=0 and `one_shot`=0**:
  - `q` ← 2^`WIDTH`−1.
  - `borrow` is high during that cycle; state stays `RUN`.
- **In `RUN` with `en`=1, `q`=0 and `one_shot`=1**: this is reachable only if `one_shot` is switched mid-count. Next state is `DONE`, `q` holds at 0, and there is no `borrow`.
- **In `RUN` with `en`=0**: `q` and state hold.
- **In `DONE`**: `q` holds at 0 and `en` is ignored. Only `load` or reset leaves this state.
- **Bit-level decrement**:
  - Cell i toggles when `j`=`k`=`t[i]`.
  - `t[0]` = `cnt_en`.
  - `t[i]` = `cnt_en` & ~`q[i−1]` & … & ~`q[0]`.
  - `cnt_en` = (state==`RUN`) & `en` & ~(`one_shot` & `q`==0).
  - A load forces every cell to `load_val[i]` regardless of `j`/`k`.
- **Arithmetic**: unsigned, modulo 2^`WIDTH`. There is no other carry or overflow output.

## Timing
- Every output changes only on a `clk` edge, except `borrow`.
- `borrow` is combinational from `q`, state, `en` and `one_shot`. It has no glitch requirement beyond a single-cycle pulse.
- **Load latency**: `q` = `load_val` and `busy` = 1 in the cycle after the `load` edge. The first decrement happens on the following edge if `en`=1.
- **One-shot sequence**: after loading N≥1 with `en` held high, `q` reaches 0 and `done` rises together, N edges after the load edge.
- **Wrap period**: with `en` held high, `borrow` pulses once every `load_val`+1 cycles on the first pass, then every 2^`WIDTH` cycles.
- **`rst_n` low mid-count**: the next edge returns all outputs to their reset values; any `load` in the same cycle is ignored.
- **`load` and `en` in the same cycle**: the load wins and no decrement occurs that edge.

## Structure
Shared package `counter_pkg`:
- State encoding `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2.
- Default width constant `CNT_W_DEFAULT`=4.

Sub-module `jkff_load_cell`, one instance per bit, generated:
- Ports: `clk`, `rst_n`, `j`, `k`, `ld`, `d`, `q`.
- Synchronous active-low reset to 0.
- `ld` has priority over `j`/`k`.
- J/K behaviour:
  - `j`=`k`=1: toggle.
  - `j`=1, `k`=0: set.
  - `j`=0, `k`=1: clear.
  - `j`=0, `k`=0: hold.

Top level holds:
- the state register;
- the toggle chain `t[]`;
- the `borrow`, `done` and `busy` decode.

## Test plan
All scenarios use `WIDTH`=4.
- **Reset**: drive `rst_n`=0 for 2 edges with `load`=1 and `load_val`=9 → `q`=0, `busy`=0, `done`=0, `borrow`=0.
- **One-shot**: set `one_shot`=1, load 5, hold `en`=1 → `q` goes 5,4,3,2,1,0; `done` rises with `q`=0 five edges after the load edge; `q` stays 0 for 10 further edges.
- **Wrap**: set `one_shot`=0, load 2, hold `en`=1 → `q` goes 2,1,0,15,14; `borrow` is high only in the `q`=0 cycle; the next `borrow` comes 16 cycles later.
- **Enable gap and reload**: load 8, toggle `en` 1,0,0,1 → `q` goes 8,7,7,7,6. Assert `load`=1 with `load_val`=3 together with `en`=1 → `q`=3 and no decrement on that edge.
- **Edge cases**: with `one_shot`=1, load 0 → `done`=1 next cycle and `borrow` is never high. Mid-count at `q`=4, pull `rst_n` low → `q`=0 and state `IDLE` on the next edge. From `IDLE`, hold `en`=1 → `q` holds at 0.
- **Bit-cell check**: with `one_shot`=0, load 0 and `en`=1 → all four cells toggle on the same edge, `q`=15.
